instr_encoder_loader: RTL

//  Encoder side of the 3-bit-opcode ISA consumed by the main decoder: accepts instruction fields over a valid/ready handshake.

---
 rtl/instr_encoder_loader.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/instr_encoder_loader.sv
// Packs instruction fields into 16-bit words and streams them into imem during a load session.
// Optional immediate range checking is enabled by defining IMM_CHECK_EN.
module instr_encoder_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [1:0]        in_funct,
  input  logic [2:0]        in_rd,
  input  logic [2:0]        in_rs1,
  input  logic [2:0]        in_rs2,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic [ADDR_W:0]   wr_count,
  output logic              imm_err,
  output logic [1:0]        dbg_state
);

  // Handshake: a word is accepted on a rising edge where in_valid && in_ready;
  // in_ready depends only on registered state, never on in_valid.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                full_q, full_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                err_q, err_d;

  logic                accept;
  logic                imm_ok;
  logic                wr_en;
  logic                last_slot;
  logic [15:0]         enc_word;

  function automatic logic [15:0] encode(
    input logic [2:0]  op,
    input logic [1:0]  funct,
    input logic [2:0]  rd,
    input logic [2:0]  rs1,
    input logic [2:0]  rs2,
    input logic [15:0] imm
  );
    logic [15:0] w;
    w = 16'h0000;
    case (op)
      3'b000:                 w = {op, rd, rs1, rs2, 2'b00, funct};
      3'b001, 3'b010:         w = {op, rd, rs1, imm[4:0], funct};
      3'b011, 3'b100, 3'b101: w = {op, rs1, rs2, imm[4:0], funct};
      3'b110:                 w = {op, rd, imm[9:0]};
      default:                w = {op, 3'b000, rs1, 7'b0000000};
    endcase
    return w;
  endfunction

  assign enc_word = encode(in_op, in_funct, in_rd, in_rs1, in_rs2, in_imm);

`ifdef IMM_CHECK_EN
  // An immediate fits a signed N-bit field when all bits above N-1 copy the sign bit.
  always_comb begin
    imm_ok = 1'b1;
    case (in_op)
      3'b001, 3'b010, 3'b011, 3'b100, 3'b101:
        imm_ok = (&in_imm[15:4]) || (~|in_imm[15:4]);
      3'b110:
        imm_ok = (&in_imm[15:9]) || (~|in_imm[15:9]);
      default:
        imm_ok = 1'b1;
    endcase
  end
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^in_imm[15:10];
  assign imm_ok        = 1'b1;
`endif

  assign in_ready  = (state_q == S_LOAD) && (cnt_q < DEPTH);
  assign accept    = in_valid && in_ready;
  assign wr_en     = accept && imm_ok;
  assign last_slot = (cnt_q == DEPTH - 1'b1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    we_d    = wr_en;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = accept && !imm_ok;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          ptr_d   = start_addr;
          cnt_d   = '0;
          full_d  = 1'b0;
        end
      end
      S_LOAD: begin
        if (wr_en) begin
          ptr_d   = ptr_q + 1'b1;
          cnt_d   = cnt_q + 1'b1;
          addr_d  = ptr_q;
          wdata_d = enc_word;
        end
        if (accept && in_last) begin
          state_d = S_DONE;
        end else if (wr_en && last_slot) begin
          state_d = S_DONE;
          full_d  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign busy       = (state_q == S_LOAD);
  assign done       = (state_q == S_DONE);
  assign full       = full_q;
  assign wr_count   = cnt_q;
  assign dbg_state  = state_q;
`ifdef IMM_CHECK_EN
  assign imm_err    = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
  assign imm_err    = 1'b0;
`endif

endmodule
